// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry decode buffer,
// redirects override everything and discard any in-flight response.
module ysyx_220053_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_fault,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_req_valid;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [63:0] r_id_pc;
  logic        r_id_fault;

  logic        w_hs;
  logic [63:0] w_pc_inc;
  logic        w_pc_misal;
  logic        w_rd_misal;

  assign w_hs       = r_req_valid & imem_req_ready;
  assign w_pc_inc   = r_pc + 64'd4;
  assign w_pc_misal = r_pc[1:0] != 2'b00;
  assign w_rd_misal = redirect_pc[1:0] != 2'b00;

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;
  assign id_fault       = r_id_fault;

  // r_req_valid is only ever raised for an aligned pc; a misaligned pc in REQ
  // turns into a faulting NOP in HOLD instead of a memory access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_id_valid  <= 1'b0;
      r_id_instr  <= 32'h0;
      r_id_pc     <= 64'h0;
      r_id_fault  <= 1'b0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (w_hs) begin
              r_state     <= S_FLUSH;
              r_req_valid <= 1'b0;
            end else begin
              r_req_valid <= !w_rd_misal;
            end
          end else if (w_hs) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end else if (w_pc_misal) begin
            r_state     <= S_HOLD;
            r_req_valid <= 1'b0;
            r_id_valid  <= 1'b1;
            r_id_instr  <= NOP;
            r_id_pc     <= r_pc;
            r_id_fault  <= 1'b1;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (imem_resp_valid) begin
              r_state     <= S_REQ;
              r_req_valid <= !w_rd_misal;
            end else begin
              r_state <= S_FLUSH;
            end
          end else if (imem_resp_valid) begin
            r_state    <= S_HOLD;
            r_id_valid <= 1'b1;
            r_id_instr <= imem_resp_data;
            r_id_pc    <= r_pc;
            r_id_fault <= imem_resp_err;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_state     <= S_REQ;
            r_pc        <= redirect_pc;
            r_req_valid <= !w_rd_misal;
            r_id_valid  <= 1'b0;
          end else if (id_ready) begin
            r_state     <= S_REQ;
            r_pc        <= w_pc_inc;
            r_req_valid <= !w_pc_misal;
            r_id_valid  <= 1'b0;
          end
        end
        S_FLUSH: begin
          // Stay here until the abandoned response drains, tracking any new target.
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (imem_resp_valid) begin
              r_state     <= S_REQ;
              r_req_valid <= !w_rd_misal;
            end
          end else if (imem_resp_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= !w_pc_misal;
          end
        end
      endcase
    end
  end
endmodule
